// File: rtl/wb_epbuf_pipe_if.sv
// ---------------------------------------------------------------------------
// WbEpbufPipeIf : Wishbone B4 pipelined bus bundle for wb_epbuf_pipe
//
// Groups the request/response signals of the pipelined Wishbone slave port.
//   wb_addr   word address                   (master -> slave, AW bits)
//   wb_wdata  write data                     (master -> slave, DW bits)
//   wb_sel    byte lane selects              (master -> slave, DW/8 bits)
//   wb_we     write enable                   (master -> slave)
//   wb_cyc    bus cycle                      (master -> slave)
//   wb_stb    request strobe                 (master -> slave)
//   wb_stall  request not accepted           (slave -> master)
//   wb_ack    transaction complete           (slave -> master)
//   wb_rdata  read data, zero without ack    (slave -> master, DW bits)
// ---------------------------------------------------------------------------
interface wb_epbuf_pipe_if #(
    parameter int AW = 9,
    parameter int DW = 32
) ();

    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_wdata;
    logic [DW/8-1:0] wb_sel;
    logic            wb_we;
    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_stall;
    logic            wb_ack;
    logic [DW-1:0]   wb_rdata;

    // The bus master drives requests and observes stall/ack/rdata
    modport master (
        output wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb,
        input  wb_stall, wb_ack, wb_rdata
    );

    // The bridge observes requests and drives stall/ack/rdata
    modport slave (
        input  wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb,
        output wb_stall, wb_ack, wb_rdata
    );

endinterface

// File: rtl/wb_epbuf_pipe.sv
// ---------------------------------------------------------------------------
// wb_epbuf_pipe : pipelined Wishbone (B4) slave bridge to the USB core
//                 TX/RX endpoint buffer ports
//
// Accepts one request per cycle, issues TX writes / RX reads in the accept
// cycle and returns in-order acks a fixed number of cycles later. The number
// of accepted but un-acked transactions is limited to MAX_OUT via wb_stall.
//
// Parameters
//   AW       word address width of the EP buffers
//   DW       data width, multiple of 8
//   RD_LAT   cycles from ep_rx_re_0 to valid ep_rx_data_1, 1..4
//   MAX_OUT  maximum outstanding transactions, 1..RD_LAT
//            (1..RD_LAT+1 with the output register stage)
//
// Ports
//   clk            clock
//   rst            asynchronous active-high reset
//   wb             Wishbone slave bundle (wb_epbuf_pipe_if.slave)
//   ep_tx_addr_0   TX buffer write address
//   ep_tx_data_0   TX buffer write data
//   ep_tx_wmsk_0   TX byte write mask, 1 = lane written
//   ep_tx_we_0     TX buffer write strobe
//   ep_rx_addr_0   RX buffer read address
//   ep_rx_data_1   RX buffer read data, valid RD_LAT cycles after re
//   ep_rx_re_0     RX buffer read enable
//
// Build option
//   WB_EPBUF_PIPE_RDREG_EN  adds an output register on wb_ack/wb_rdata;
//                           ack latency becomes RD_LAT+1.
// ---------------------------------------------------------------------------
module wb_epbuf_pipe #(
    parameter int AW      = 9,
    parameter int DW      = 32,
    parameter int RD_LAT  = 1,
    parameter int MAX_OUT = RD_LAT
) (
    input  logic                clk,
    input  logic                rst,
    wb_epbuf_pipe_if.slave      wb,
    output logic [AW-1:0]       ep_tx_addr_0,
    output logic [DW-1:0]       ep_tx_data_0,
    output logic [DW/8-1:0]     ep_tx_wmsk_0,
    output logic                ep_tx_we_0,
    output logic [AW-1:0]       ep_rx_addr_0,
    input  logic [DW-1:0]       ep_rx_data_1,
    output logic                ep_rx_re_0
);

    localparam int CW = (MAX_OUT < 1) ? 1 : $clog2(MAX_OUT + 1);

    logic              acc;
    logic              stall;
    logic              retire;
    logic              tailAck;
    logic [DW-1:0]     tailData;

    logic [RD_LAT-1:0] validPipe_q, validPipe_d;
    logic [RD_LAT-1:0] readPipe_q,  readPipe_d;
    logic [CW-1:0]     outCnt_q,    outCnt_d;

    // Accept qualifier; gating with rst keeps the EP strobes quiet during
    // reset even though the bus may still be requesting.
    always_comb begin
        acc = wb.wb_cyc & wb.wb_stb & ~stall & ~rst;
    end

    // Address, data and mask go straight through; only the strobes are
    // qualified, so a write with no lanes selected never touches the TX
    // buffer but still travels down the ack pipeline.
    always_comb begin
        ep_tx_addr_0 = wb.wb_addr;
        ep_rx_addr_0 = wb.wb_addr;
        ep_tx_data_0 = wb.wb_wdata;
        ep_tx_wmsk_0 = wb.wb_sel;
        ep_tx_we_0   = acc & wb.wb_we & (|wb.wb_sel);
        ep_rx_re_0   = acc & ~wb.wb_we;
    end

    // Next state of the ack pipeline. Every accepted transaction enters
    // stage 0 and reaches the tail exactly RD_LAT edges later, which lines
    // up with the RX buffer read data. The is-read bit travels alongside so
    // write acks return zero data. Dropping wb_cyc flushes everything.
    always_comb begin
        validPipe_d    = '0;
        readPipe_d     = '0;
        validPipe_d[0] = acc;
        readPipe_d[0]  = acc & ~wb.wb_we;
        for (int i = 1; i < RD_LAT; i++) begin
            validPipe_d[i] = validPipe_q[i-1];
            readPipe_d[i]  = readPipe_q[i-1];
        end
        if (!wb.wb_cyc) begin
            validPipe_d = '0;
            readPipe_d  = '0;
        end
    end

    // Ack pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validPipe_q <= '0;
            readPipe_q  <= '0;
        end else begin
            validPipe_q <= validPipe_d;
            readPipe_q  <= readPipe_d;
        end
    end

    // Tail of the pipeline; the ack is suppressed while wb_cyc is low so an
    // abort in the same cycle as a tail ack wins.
    always_comb begin
        tailAck  = validPipe_q[RD_LAT-1] & wb.wb_cyc;
        tailData = (tailAck & readPipe_q[RD_LAT-1]) ? ep_rx_data_1 : '0;
    end

`ifdef WB_EPBUF_PIPE_RDREG_EN
    logic          ackOut_q,   ackOut_d;
    logic [DW-1:0] rdataOut_q, rdataOut_d;

    // Output stage next state; tailAck/tailData are already zero when wb_cyc
    // is low, so an abort clears this stage on the same edge as the pipe.
    always_comb begin
        ackOut_d   = tailAck;
        rdataOut_d = tailData;
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ackOut_q   <= 1'b0;
            rdataOut_q <= '0;
        end else begin
            ackOut_q   <= ackOut_d;
            rdataOut_q <= rdataOut_d;
        end
    end

    // Registered response, still forced low while the cycle is dropped
    always_comb begin
        wb.wb_ack   = ackOut_q & wb.wb_cyc;
        wb.wb_rdata = (ackOut_q & wb.wb_cyc) ? rdataOut_q : '0;
    end
`else
    // Combinational response straight from the pipeline tail
    always_comb begin
        wb.wb_ack   = tailAck;
        wb.wb_rdata = tailData;
    end
`endif

    // A slot is freed by whatever ack the master actually sees, so the
    // stall can release in the very cycle the ack retires.
    always_comb begin
        retire = wb.wb_ack;
        stall  = (outCnt_q == CW'(MAX_OUT)) & ~retire;
        wb.wb_stall = stall;
    end

    // Outstanding counter next state: accept and retire together hold it
    always_comb begin
        outCnt_d = outCnt_q;
        unique case ({acc, retire})
            2'b10:   outCnt_d = outCnt_q + CW'(1);
            2'b01:   outCnt_d = outCnt_q - CW'(1);
            default: outCnt_d = outCnt_q;
        endcase
        if (!wb.wb_cyc) begin
            outCnt_d = '0;
        end
    end

    // Outstanding counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outCnt_q <= '0;
        end else begin
            outCnt_q <= outCnt_d;
        end
    end

endmodule

// File: tb/tb_wb_epbuf_pipe.sv
// ---------------------------------------------------------------------------
// tb_wb_epbuf_pipe : self-checking bench for wb_epbuf_pipe
//
// Runs the bridge with RD_LAT=3, MAX_OUT=2 so that pipelining, stall and
// stall release all occur. Expected responses (due cycle + data) are queued
// when a request is accepted and popped when the ack is due. An RX buffer
// model returns addr+0x100 RD_LAT cycles after a read enable.
// ---------------------------------------------------------------------------
module tb_wb_epbuf_pipe;

    localparam int AW      = 9;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int RD_LAT  = 3;
    localparam int MAX_OUT = 2;
`ifdef WB_EPBUF_PIPE_RDREG_EN
    localparam int LAT = RD_LAT + 1;
`else
    localparam int LAT = RD_LAT;
`endif
    localparam logic [DW-1:0] JUNK = 32'hA5A5_0000;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [AW-1:0] ep_tx_addr_0;
    logic [DW-1:0] ep_tx_data_0;
    logic [SW-1:0] ep_tx_wmsk_0;
    logic          ep_tx_we_0;
    logic [AW-1:0] ep_rx_addr_0;
    logic [DW-1:0] ep_rx_data_1;
    logic          ep_rx_re_0;

    int   checks   = 0;
    int   errors   = 0;
    int   cycleNum = 0;
    exp_t q[$];

    logic [DW-1:0] rxPipe [RD_LAT];

    wb_epbuf_pipe_if #(.AW(AW), .DW(DW)) bus ();

    wb_epbuf_pipe #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (bus.slave),
        .ep_tx_addr_0 (ep_tx_addr_0),
        .ep_tx_data_0 (ep_tx_data_0),
        .ep_tx_wmsk_0 (ep_tx_wmsk_0),
        .ep_tx_we_0   (ep_tx_we_0),
        .ep_rx_addr_0 (ep_rx_addr_0),
        .ep_rx_data_1 (ep_rx_data_1),
        .ep_rx_re_0   (ep_rx_re_0)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Cycle counter used for ack due times
    always @(posedge clk) cycleNum <= cycleNum + 1;

    // RX buffer content seen by reads
    function automatic logic [DW-1:0] rdModel(input logic [AW-1:0] a);
        return {{(DW-AW){1'b0}}, a} + DW'(256);
    endfunction

    // RX buffer model: data appears RD_LAT cycles after a read enable;
    // non-read slots carry junk so ungated rdata shows up
    always @(posedge clk) begin
        rxPipe[0] <= ep_rx_re_0 ? rdModel(ep_rx_addr_0) : (JUNK | DW'(ep_rx_addr_0));
        for (int i = 1; i < RD_LAT; i++) rxPipe[i] <= rxPipe[i-1];
    end
    assign ep_rx_data_1 = rxPipe[RD_LAT-1];

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cycleNum, act, exp);
        end
    endtask

    // Drive one cycle of bus inputs, check all outputs at the falling edge,
    // update the scoreboard and return whether the request was accepted
    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                 input logic [SW-1:0] sel, output logic accepted);
        logic expAck;
        logic expStall;
        exp_t e;
        bus.wb_cyc   = cyc;
        bus.wb_stb   = stb;
        bus.wb_we    = we;
        bus.wb_addr  = addr;
        bus.wb_wdata = wd;
        bus.wb_sel   = sel;
        @(negedge clk);
        expAck   = cyc && (q.size() > 0) && (q[0].due == cycleNum);
        expStall = (q.size() == MAX_OUT) && !expAck;
        accepted = cyc && stb && !expStall;
        checkOutput("ack",   bus.wb_ack,   expAck);
        checkOutput("stall", bus.wb_stall, expStall);
        checkOutput("txWe",  ep_tx_we_0,   accepted && we && (|sel));
        checkOutput("rxRe",  ep_rx_re_0,   accepted && !we);
        if (expAck) checkOutput("rdata", bus.wb_rdata, q[0].data);
        else        checkOutput("rdataIdle", bus.wb_rdata, 0);
        if (accepted) begin
            checkOutput("txAddr", ep_tx_addr_0, addr);
            checkOutput("rxAddr", ep_rx_addr_0, addr);
            checkOutput("txData", ep_tx_data_0, wd);
            checkOutput("txWmsk", ep_tx_wmsk_0, sel);
        end
        if (expAck) void'(q.pop_front());
        if (accepted) begin
            e.due  = cycleNum + LAT;
            e.data = we ? '0 : rdModel(addr);
            q.push_back(e);
        end
        if (!cyc) q.delete();
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted, bounded
    task automatic doReq(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [SW-1:0] sel);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 16) begin
            applyStimulus(1'b1, 1'b1, we, addr, wd, sel, acc);
            tries++;
        end
        if (!acc) checkOutput("reqTimeout", 0, 1);
    endtask

    // Idle cycles with the given cyc level
    task automatic idle(input int n, input logic cyc);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(cyc, 1'b0, 1'b0, '0, '0, '0, acc);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic          acc;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic [SW-1:0] rs;

        // Requests held during reset must not reach the EP buffers
        bus.wb_cyc   = 1'b1;
        bus.wb_stb   = 1'b1;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = 9'h055;
        bus.wb_wdata = 32'h1234_5678;
        bus.wb_sel   = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstAck0",   bus.wb_ack,   0);
        checkOutput("rstStall0", bus.wb_stall, 0);
        checkOutput("rstRe0",    ep_rx_re_0,   0);
        bus.wb_we = 1'b1;
        #1;
        checkOutput("rstWe0", ep_tx_we_0, 0);
        bus.wb_cyc = 1'b0;
        bus.wb_stb = 1'b0;
        rst        = 1'b0;
        @(posedge clk);
        #1;
        idle(2, 1'b0);

        $display("[TB] single write");
        doReq(1'b1, 9'h012, 32'hDEAD_BEEF, 4'hF);
        idle(LAT + 2, 1'b1);

        $display("[TB] back-to-back reads");
        for (int i = 0; i < 4; i++) doReq(1'b0, AW'(i), '0, 4'hF);
        idle(LAT + 2, 1'b1);

        $display("[TB] mixed sequence");
        doReq(1'b1, 9'h040, 32'h0000_A5A5, 4'h3);
        doReq(1'b0, 9'h041, 32'h0,         4'hF);
        doReq(1'b1, 9'h042, 32'hFFFF_FFFF, 4'h0);
        doReq(1'b0, 9'h043, 32'h0,         4'hF);
        idle(LAT + 2, 1'b1);

        $display("[TB] abort");
        doReq(1'b0, 9'h020, '0, 4'hF);
        doReq(1'b0, 9'h021, '0, 4'hF);
        idle(1, 1'b0);
        idle(LAT + 2, 1'b1);
        doReq(1'b0, 9'h022, '0, 4'hF);
        idle(LAT + 2, 1'b1);

        $display("[TB] reset mid-burst");
        doReq(1'b0, 9'h030, '0, 4'hF);
        doReq(1'b0, 9'h031, '0, 4'hF);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstAck",   bus.wb_ack,   0);
        checkOutput("rstStall", bus.wb_stall, 0);
        q.delete();
        repeat (2) begin
            @(negedge clk);
            checkOutput("rstRe", ep_rx_re_0, 0);
        end
        bus.wb_stb = 1'b0;
        rst        = 1'b0;
        @(posedge clk);
        #1;
        idle(LAT + 2, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            ra = AW'($urandom);
            rd = $urandom;
            rs = SW'($urandom);
            applyStimulus($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ra, rd, rs, acc);
        end
        idle(LAT + 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
